// File: rtl/subleq_sequencer.sv
// subleq_sequencer: instruction-cycle control FSM for the Subleq CPU.
// Walks fetch A/B/C, load mem[A]/mem[B], store mem[B]-mem[A], then PC update.
// Memory completion is either a fixed wait-state count or an ack handshake.
// The datapath owns PC, operand registers and the ALU; this block only
// drives its mux selects and write strobes.
module subleq_sequencer #(
    parameter int unsigned ACK_MODE = 0,
    parameter int unsigned MEM_LAT  = 0,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             step,
    input  logic             mem_ack,
    input  logic             leq,
    input  logic             halt_tgt,
    output logic             mem_req,
    output logic             mem_we,
    output logic [2:0]       addr_sel,
    output logic             a_we,
    output logic             b_we,
    output logic             c_we,
    output logic             opa_we,
    output logic             opb_we,
    output logic             pc_we,
    output logic             pc_sel,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH_A,
        S_FETCH_B,
        S_FETCH_C,
        S_LOAD_A,
        S_LOAD_B,
        S_STORE,
        S_NEXT,
        S_HALT
    } state_t;

    localparam logic [3:0] LAT     = 4'(MEM_LAT);
    localparam bit         USE_ACK = (ACK_MODE != 0);

    state_t           r_state;
    state_t           w_next;
    logic [3:0]       r_wait_cnt;
    logic             r_leq_q;
    logic             r_step_q;
    logic [CNT_W-1:0] r_instr_cnt;
    logic             w_mem_state;
    logic             w_done;
    logic             w_retire;

    // Completion of the current memory access: ack handshake or wait-state match.
    always_comb begin
        w_mem_state = r_state inside {S_FETCH_A, S_FETCH_B, S_FETCH_C,
                                      S_LOAD_A, S_LOAD_B, S_STORE};
        w_done      = w_mem_state && (USE_ACK ? mem_ack : (r_wait_cnt == LAT));
    end

    // Next-state decode plus all control outputs; outputs are Moore-like except
    // the strobes, which fire only in the completion cycle of their state.
    // NOTE: every output gets a default before the case so no path leaves one
    // unassigned; a missing default here would infer a latch.
    always_comb begin
        w_next    = r_state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 3'd0;
        a_we      = 1'b0;
        b_we      = 1'b0;
        c_we      = 1'b0;
        opa_we    = 1'b0;
        opb_we    = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = 1'b0;
        halted    = 1'b0;
        w_retire  = 1'b0;
        busy      = (r_state != S_IDLE) && (r_state != S_HALT);
        instr_cnt = r_instr_cnt;

        case (r_state)
            S_IDLE: begin
                if (run || step) w_next = S_FETCH_A;
            end
            S_FETCH_A: begin
                mem_req  = 1'b1;
                addr_sel = 3'd0;
                a_we     = w_done;
                if (w_done) w_next = S_FETCH_B;
            end
            S_FETCH_B: begin
                mem_req  = 1'b1;
                addr_sel = 3'd1;
                b_we     = w_done;
                if (w_done) w_next = S_FETCH_C;
            end
            S_FETCH_C: begin
                mem_req  = 1'b1;
                addr_sel = 3'd2;
                c_we     = w_done;
                if (w_done) w_next = S_LOAD_A;
            end
            S_LOAD_A: begin
                mem_req  = 1'b1;
                addr_sel = 3'd3;
                opa_we   = w_done;
                if (w_done) w_next = S_LOAD_B;
            end
            S_LOAD_B: begin
                mem_req  = 1'b1;
                addr_sel = 3'd4;
                opb_we   = w_done;
                if (w_done) w_next = S_STORE;
            end
            S_STORE: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                addr_sel = 3'd4;
                if (w_done) w_next = S_NEXT;
            end
            S_NEXT: begin
                w_retire = 1'b1;
                if (r_leq_q && halt_tgt) begin
                    w_next = S_HALT;
                end else begin
                    pc_we  = 1'b1;
                    pc_sel = r_leq_q;
                    w_next = (r_step_q || !run) ? S_IDLE : S_FETCH_A;
                end
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State register; reset forces IDLE so mem_req drops asynchronously.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Wait-state counter, step/branch flags and retired-instruction counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt  <= 4'd0;
            r_leq_q     <= 1'b0;
            r_step_q    <= 1'b0;
            r_instr_cnt <= '0;
        end else begin
            if (w_mem_state && !w_done && !USE_ACK) r_wait_cnt <= r_wait_cnt + 4'd1;
            else                                    r_wait_cnt <= 4'd0;

            if (r_state == S_IDLE) begin
                if (run)       r_step_q <= 1'b0;
                else if (step) r_step_q <= 1'b1;
            end

            if (r_state == S_STORE && w_done) r_leq_q <= leq;

            if (w_retire) r_instr_cnt <= r_instr_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_subleq_sequencer.sv
// Testbench for subleq_sequencer: three instances (MEM_LAT=0, MEM_LAT=2,
// ACK_MODE=1). Expected per-cycle output traces are queued when stimulus is
// issued; a monitor pops and compares on every busy cycle of each instance.
`timescale 1ns/1ps
module tb_subleq_sequencer;

    typedef struct packed {
        logic        mem_req;
        logic        mem_we;
        logic [2:0]  addr_sel;
        logic        a_we;
        logic        b_we;
        logic        c_we;
        logic        opa_we;
        logic        opb_we;
        logic        pc_we;
        logic        pc_sel;
        logic        busy;
        logic        halted;
        logic [15:0] cnt;
    } out_t;

    logic        clk;
    logic        rst_n;
    logic        run      [3];
    logic        step     [3];
    logic        mem_ack  [3];
    logic        leq      [3];
    logic        halt_tgt [3];
    logic        mem_req  [3];
    logic        mem_we   [3];
    logic [2:0]  addr_sel [3];
    logic        a_we     [3];
    logic        b_we     [3];
    logic        c_we     [3];
    logic        opa_we   [3];
    logic        opb_we   [3];
    logic        pc_we    [3];
    logic        pc_sel   [3];
    logic        busy     [3];
    logic        halted   [3];
    logic [15:0] instr_cnt[3];
    out_t        act      [3];

    out_t q0[$];
    out_t q1[$];
    out_t q2[$];

    int n_checks = 0;
    int n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        subleq_sequencer #(
            .ACK_MODE (g == 2 ? 1 : 0),
            .MEM_LAT  (g == 1 ? 2 : 0),
            .CNT_W    (16)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .run       (run[g]),
            .step      (step[g]),
            .mem_ack   (mem_ack[g]),
            .leq       (leq[g]),
            .halt_tgt  (halt_tgt[g]),
            .mem_req   (mem_req[g]),
            .mem_we    (mem_we[g]),
            .addr_sel  (addr_sel[g]),
            .a_we      (a_we[g]),
            .b_we      (b_we[g]),
            .c_we      (c_we[g]),
            .opa_we    (opa_we[g]),
            .opb_we    (opb_we[g]),
            .pc_we     (pc_we[g]),
            .pc_sel    (pc_sel[g]),
            .busy      (busy[g]),
            .halted    (halted[g]),
            .instr_cnt (instr_cnt[g])
        );
        assign act[g] = {mem_req[g], mem_we[g], addr_sel[g], a_we[g], b_we[g], c_we[g],
                         opa_we[g], opb_we[g], pc_we[g], pc_sel[g], busy[g], halted[g],
                         instr_cnt[g]};
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int idx, input out_t v);
        case (idx)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    function automatic int qsize(input int idx);
        case (idx)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic out_t pop_exp(input int idx);
        case (idx)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    // Expected trace of one memory state: lat hold cycles then one done cycle.
    task automatic push_mem_state(input int idx, input int k, input int lat,
                                  input logic [15:0] cnt);
        out_t e;
        for (int w = 0; w <= lat; w++) begin
            e          = '0;
            e.mem_req  = 1'b1;
            e.mem_we   = (k == 5);
            e.addr_sel = 3'(k < 5 ? k : 4);
            e.busy     = 1'b1;
            e.cnt      = cnt;
            if (w == lat) begin
                case (k)
                    0: e.a_we   = 1'b1;
                    1: e.b_we   = 1'b1;
                    2: e.c_we   = 1'b1;
                    3: e.opa_we = 1'b1;
                    4: e.opb_we = 1'b1;
                    default: ;
                endcase
            end
            push(idx, e);
        end
    endtask

    // Full instruction trace; lats packs six 4-bit hold counts, FETCH_A lowest.
    task automatic push_instr(input int idx, input logic [23:0] lats, input logic leq_v,
                              input logic halt_v, input logic [15:0] cnt);
        out_t e;
        for (int k = 0; k < 6; k++) push_mem_state(idx, k, int'(lats[k*4 +: 4]), cnt);
        e        = '0;
        e.busy   = 1'b1;
        e.cnt    = cnt;
        e.pc_we  = !(leq_v && halt_v);
        e.pc_sel = leq_v && !halt_v;
        push(idx, e);
    endtask

    // Monitor: every busy cycle of each instance must match the next queued entry.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst_n && act[i].busy) begin
                if (qsize(i) == 0)
                    check($sformatf("unexpected_busy_dut%0d", i), 64'(act[i].busy), 64'd0);
                else
                    check($sformatf("trace_dut%0d", i), 64'(act[i]), 64'(pop_exp(i)));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] ack_lats;
        ack_lats = 24'h205130;   // FETCH_A..STORE delays 0,3,1,5,0,2
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            run[i] = 1'b0; step[i] = 1'b0; mem_ack[i] = 1'b0;
            leq[i] = 1'b0; halt_tgt[i] = 1'b0;
        end
        repeat (3) tick();
        rst_n = 1'b1;

        // Reset and idle: all outputs stay zero for 10 cycles.
        for (int c = 0; c < 10; c++) begin
            tick();
            for (int i = 0; i < 3; i++) check($sformatf("idle_dut%0d", i), 64'(act[i]), 64'd0);
        end

        // Single step, MEM_LAT=0, no branch.
        push_instr(0, 24'h000000, 1'b0, 1'b0, 16'd0);
        step[0] = 1'b1;
        tick();
        step[0] = 1'b0;
        repeat (10) tick();
        check("step_busy", 64'(busy[0]), 64'd0);
        check("step_cnt", 64'(instr_cnt[0]), 64'd1);

        // Free run with branch, MEM_LAT=2; stray step while busy; run drops in LOAD_A of instr 2.
        leq[1] = 1'b1;
        push_instr(1, 24'h222222, 1'b1, 1'b0, 16'd0);
        push_instr(1, 24'h222222, 1'b1, 1'b0, 16'd1);
        run[1] = 1'b1;
        tick();
        repeat (5) tick();
        step[1] = 1'b1;
        tick();
        step[1] = 1'b0;
        repeat (23) tick();
        check("run_drop_in_load_a", 64'(addr_sel[1]), 64'd3);
        run[1] = 1'b0;
        repeat (15) tick();
        check("run_busy", 64'(busy[1]), 64'd0);
        check("run_cnt", 64'(instr_cnt[1]), 64'd2);
        check("run_trace_drained", 64'(q1.size()), 64'd0);

        // Ack mode: variable delays; leq changes after STORE must not affect pc_sel.
        leq[2] = 1'b1;
        push_instr(2, ack_lats, 1'b0, 1'b0, 16'd0);
        step[2] = 1'b1;
        tick();
        step[2] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            for (int w = 0; w < int'(ack_lats[k*4 +: 4]); w++) begin
                mem_ack[2] = 1'b0;
                tick();
            end
            if (k == 5) leq[2] = 1'b0;
            mem_ack[2] = 1'b1;
            tick();
        end
        leq[2] = 1'b1;           // NEXT cycle: ack and leq both irrelevant here
        repeat (4) tick();
        check("ack_busy", 64'(busy[2]), 64'd0);
        check("ack_cnt", 64'(instr_cnt[2]), 64'd1);
        mem_ack[2] = 1'b0;
        leq[2] = 1'b0;

        // Halt: leq=1 and halt_tgt=1 at NEXT.
        leq[0] = 1'b1;
        halt_tgt[0] = 1'b1;
        push_instr(0, 24'h000000, 1'b1, 1'b1, 16'd1);
        step[0] = 1'b1;
        tick();
        step[0] = 1'b0;
        repeat (10) tick();
        check("halt_halted", 64'(halted[0]), 64'd1);
        check("halt_busy", 64'(busy[0]), 64'd0);
        check("halt_cnt", 64'(instr_cnt[0]), 64'd2);
        run[0] = 1'b1;
        step[0] = 1'b1;
        tick();
        step[0] = 1'b0;
        repeat (5) tick();
        check("halt_sticky", 64'(act[0]), 64'({1'b0, 1'b0, 3'd0, 9'b000000001, 16'd2}));
        run[0] = 1'b0;

        // Reset during STORE on the ack instance: five done cycles, one STORE hold.
        for (int k = 0; k < 5; k++) push_mem_state(2, k, 0, 16'd1);
        begin
            out_t e;
            e = '0; e.mem_req = 1'b1; e.mem_we = 1'b1; e.addr_sel = 3'd4;
            e.busy = 1'b1; e.cnt = 16'd1;
            push(2, e);
        end
        step[2] = 1'b1;
        tick();
        step[2] = 1'b0;
        mem_ack[2] = 1'b1;
        repeat (5) tick();
        mem_ack[2] = 1'b0;
        tick();
        check("store_active", 64'(mem_we[2]), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mem_req", 64'(mem_req[2]), 64'd0);
        check("rst_cnt", 64'(instr_cnt[2]), 64'd0);
        check("rst_unhalt", 64'(halted[0]), 64'd0);
        #2;
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) check($sformatf("post_rst_dut%0d", i), 64'(act[i]), 64'd0);

        for (int i = 0; i < 3; i++) check($sformatf("queue_empty_dut%0d", i), 64'(qsize(i)), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/subleq_sequencer.md
Name: subleq_sequencer

Overview:
- Parametrised next-generation control sequencer for the Subleq CPU.
- Steps the full instruction cycle: fetch operand addresses A, B, C; load mem[A] and mem[B]; store mem[B]-mem[A] back to mem[B]; update PC.
- Supports variable-latency memory (fixed wait states or ack handshake), run/single-step control, halt detection and a retired-instruction counter.
- Drives datapath mux selects and register write strobes; the datapath owns PC, operand registers and the ALU.

Parameters:
- ACK_MODE, 0, 0 = fixed-latency memory (MEM_LAT); 1 = each access completes on mem_ack.
- MEM_LAT, 0, extra wait cycles per access when ACK_MODE=0 (range 0..15).
- CNT_W, 16, width of instr_cnt.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  level: free-run instructions while high.
- step  in  1  one-cycle pulse: execute exactly one instruction from IDLE.
- mem_ack  in  1  access complete (used only when ACK_MODE=1).
- leq  in  1  datapath flag: mem[B]-mem[A] <= 0; sampled at STORE completion.
- halt_tgt  in  1  datapath flag: C operand is all-ones (halt address).
- mem_req  out  1  memory access active.
- mem_we  out  1  write access (STORE only).
- addr_sel  out  3  address mux: 0=PC, 1=PC+1, 2=PC+2, 3=A reg, 4=B reg.
- a_we, b_we, c_we  out  1 each  latch fetched A/B/C address.
- opa_we, opb_we  out  1 each  latch loaded operands.
- pc_we  out  1  PC write.
- pc_sel  out  1  PC source: 0=PC+3, 1=C.
- busy  out  1  state not IDLE and not HALT.
- halted  out  1  state is HALT.
- instr_cnt  out  CNT_W  retired instructions.

Behaviour:
- Reset (async, rst_n low): state=IDLE, wait counter=0, leq_q=0, step_q=0, instr_cnt=0. All outputs 0, addr_sel=0.
- States: IDLE, FETCH_A, FETCH_B, FETCH_C, LOAD_A, LOAD_B, STORE, NEXT, HALT.
- IDLE:
  - run=1 -> FETCH_A, step_q=0.
  - else step=1 -> FETCH_A, step_q=1.
  - run has priority over step.
- Memory states:
  - mem_req=1 for the whole state.
  - addr_sel: FETCH_A 0, FETCH_B 1, FETCH_C 2, LOAD_A 3, LOAD_B 4, STORE 4.
  - mem_we=1 only in STORE.
- Completion ("done"):
  - ACK_MODE=1: done = mem_ack.
  - ACK_MODE=0: done when the wait counter equals MEM_LAT. Counter increments each cycle in the state and clears on done.
  - mem_ack outside a memory state is ignored.
- Strobes are asserted combinationally in the done cycle only:
  - FETCH_A a_we, FETCH_B b_we, FETCH_C c_we, LOAD_A opa_we, LOAD_B opb_we.
  - STORE: leq_q <= leq.
- Transitions on done: FETCH_A->FETCH_B->FETCH_C->LOAD_A->LOAD_B->STORE->NEXT.
- NEXT (always 1 cycle):
  - leq_q=1 and halt_tgt=1: pc_we=0 -> HALT; instr_cnt increments.
  - Otherwise: pc_we=1, pc_sel=leq_q, instr_cnt increments (wraps at 2^CNT_W), then:
    - step_q=1 or run=0 -> IDLE.
    - else -> FETCH_A.
- HALT: sticky, halted=1; run and step ignored; exit only by reset.
- run dropping mid-instruction: the instruction completes; the sequencer stops in IDLE after NEXT.
- step while busy: ignored.
- Latency per instruction: 6*(MEM_LAT+1)+1 cycles (ACK_MODE=0). MEM_LAT=0 gives 7 cycles.
- Reset mid-operation: immediate IDLE; any pending access is abandoned; mem_req deasserts asynchronously.

Test Plan:
- Reset + idle:
  - rst_n low then high, run=0, step=0 -> all outputs 0, busy=0, state stays IDLE for 10 cycles.
- Single step, no branch (MEM_LAT=0, leq=0):
  - step pulse -> addr_sel 0,1,2,3,4,4 on consecutive cycles with matching strobes; mem_we only in cycle 6.
  - Cycle 7: pc_we=1, pc_sel=0, instr_cnt=1, then IDLE.
- Free run with branch (MEM_LAT=2, run=1, leq=1 at STORE):
  - Each memory state lasts 3 cycles; instruction takes 19 cycles; pc_sel=1.
  - The next FETCH_A follows NEXT immediately.
- Ack mode (ACK_MODE=1):
  - mem_ack delayed 0/3/1/5/0/2 cycles per state -> each state holds with mem_req=1 until its ack; strobes appear only in the ack cycles.
- Halt:
  - leq=1 and halt_tgt=1 at NEXT -> pc_we=0, halted=1, instr_cnt increments.
  - Subsequent run and step pulses cause no change.
- Run drop and reset:
  - run falls during LOAD_A -> instruction completes, then IDLE.
  - Separately, rst_n low during STORE -> mem_req=0 immediately and instr_cnt=0.
